// File: rtl/debounce_pkg.sv
// Shared state encoding and default timing for the push-button debouncer array.
// Defaults assume the 50 MHz board clock: 1 ms lockout, 10 ms to first repeat, 2 ms repeat rate.
package debounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHOT  = 3'd1,
        ST_LOCK1 = 3'd2,
        ST_HELD  = 3'd3,
        ST_REL   = 3'd4,
        ST_LOCK0 = 3'd5
    } dbc_state_t;

    localparam int unsigned DEF_CNT_W           = 20;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 500000;
    localparam int unsigned DEF_REPEAT_RATE     = 100000;

    // Debounced level implied by a state; illegal encodings read as released.
    function automatic logic level_of(dbc_state_t s);
        return (s == ST_SHOT) || (s == ST_LOCK1) || (s == ST_HELD);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, first-edge FSM with lockout counter,
// and auto-repeat timing. All outputs are registered from the next-state decode.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Switch,
    output logic Sw_Clean,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Repeat_Pulse
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             REP_ON     = (REPEAT_EN != 0);

    logic             sync_meta, sync;
    dbc_state_t       st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rep_done, rep_done_n;
    logic             rep_n;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= Switch;
            sync      <= sync_meta;
        end
    end

    always_comb begin
        st_n       = st;
        cnt_n      = cnt;
        rep_done_n = rep_done;
        case (st)
            ST_IDLE: begin
                cnt_n = '0;
                if (sync) st_n = ST_SHOT;
            end
            ST_SHOT: begin
                cnt_n      = '0;
                rep_done_n = 1'b0;
                st_n       = ST_LOCK1;
            end
            ST_LOCK1: begin
                if (cnt == DB_LAST) begin
                    cnt_n = '0;
                    st_n  = ST_HELD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!sync) begin
                    st_n = ST_REL;
                end else if (!REP_ON) begin
                    cnt_n = '0;
                end else if (cnt == (rep_done ? RATE_LAST : DELAY_LAST)) begin
                    cnt_n      = '0;
                    rep_done_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_REL: begin
                cnt_n = '0;
                st_n  = ST_LOCK0;
            end
            ST_LOCK0: begin
                if (cnt == DB_LAST) begin
                    cnt_n = '0;
                    st_n  = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                st_n       = ST_IDLE;
                cnt_n      = '0;
                rep_done_n = 1'b0;
            end
        endcase
    end

    // Repeat fires in the cycle the count hits its target, provided sync is still
    // high then; sync_meta is next cycle's sync, so a coinciding release suppresses it.
    always_comb begin
        rep_n = REP_ON && (st_n == ST_HELD) && sync_meta &&
                (cnt_n == (rep_done_n ? RATE_LAST : DELAY_LAST));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            st            <= ST_IDLE;
            cnt           <= '0;
            rep_done      <= 1'b0;
            Sw_Clean      <= 1'b0;
            Press_Pulse   <= 1'b0;
            Release_Pulse <= 1'b0;
            Repeat_Pulse  <= 1'b0;
        end else begin
            st            <= st_n;
            cnt           <= cnt_n;
            rep_done      <= rep_done_n;
            Sw_Clean      <= level_of(st_n);
            Press_Pulse   <= (st_n == ST_SHOT);
            Release_Pulse <= (st_n == ST_REL);
            Repeat_Pulse  <= rep_n;
        end
    end

endmodule

// File: rtl/debounce_array.sv
// CHANNELS independent debounce lanes plus an any-press strobe for the game FSMs.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] Switch,
    output logic [CHANNELS-1:0] Sw_Clean,
    output logic [CHANNELS-1:0] Press_Pulse,
    output logic [CHANNELS-1:0] Release_Pulse,
    output logic [CHANNELS-1:0] Repeat_Pulse,
    output logic                Any_Press
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .Clock         (Clock),
            .Reset         (Reset),
            .Switch        (Switch[i]),
            .Sw_Clean      (Sw_Clean[i]),
            .Press_Pulse   (Press_Pulse[i]),
            .Release_Pulse (Release_Pulse[i]),
            .Repeat_Pulse  (Repeat_Pulse[i])
        );
    end

    // OR of registered pulses, so still a clean one-clock strobe.
    assign Any_Press = |Press_Pulse;

endmodule
